// File: rtl/vending_machine.sv
// Coin-operated soda vendor: edge-detected coins accumulate credit in nickels and
// a completing coin yields a one-cycle dispense pulse with the change owed.
module vending_machine #(
    parameter int PRICE = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       quarter_in,
    output logic       soda_out,
    output logic [3:0] change_out
);

    localparam logic [3:0] PRICE_N = 4'(PRICE / 5);

    // State value equals the credit held, in nickels; only states below PRICE are reachable.
    typedef enum logic [2:0] {S0, S5, S10, S15, S20, S25, S30} state_t;

    state_t     state;
    logic       nickel_p0;
    logic       dime_p0;
    logic       quarter_p0;
    logic       nickel_rise;
    logic       dime_rise;
    logic       quarter_rise;
    logic [3:0] coin_n;
    logic [3:0] total_n;

    function automatic logic [3:0] coin_value(input logic n, input logic d, input logic q);
        if (q)
            return 4'd5;
        else if (d)
            return 4'd2;
        else if (n)
            return 4'd1;
        else
            return 4'd0;
    endfunction

    assign nickel_rise  = nickel_in  & ~nickel_p0;
    assign dime_rise    = dime_in    & ~dime_p0;
    assign quarter_rise = quarter_in & ~quarter_p0;

    always_comb begin
        coin_n  = coin_value(nickel_rise, dime_rise, quarter_rise);
        total_n = {1'b0, state} + coin_n;
    end

    // p0 boundary: previous coin samples, credit state and registered vend outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S0;
            nickel_p0  <= 1'b0;
            dime_p0    <= 1'b0;
            quarter_p0 <= 1'b0;
            soda_out   <= 1'b0;
            change_out <= 4'd0;
        end else begin
            nickel_p0  <= nickel_in;
            dime_p0    <= dime_in;
            quarter_p0 <= quarter_in;
            soda_out   <= 1'b0;
            change_out <= 4'd0;
            if (coin_n != 4'd0) begin
                if (total_n >= PRICE_N) begin
                    soda_out   <= 1'b1;
                    change_out <= total_n - PRICE_N;
                    state      <= S0;
                end else begin
                    state <= state_t'(total_n[2:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: the driver queues each expected vend with
// its cycle, and a forked monitor matches every dispense pulse against the queue.
module tb_vending_machine;

    logic       clk;
    logic       reset;
    logic       nickel_in;
    logic       dime_in;
    logic       quarter_in;
    logic       soda_out;
    logic [3:0] change_out;

    typedef struct {
        int cyc;
        int ch;
    } exp_t;

    exp_t expq[$];
    int   cyc;
    int   vectors;
    int   errors;

    vending_machine #(.PRICE(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .nickel_in  (nickel_in),
        .dime_in    (dime_in),
        .quarter_in (quarter_in),
        .soda_out   (soda_out),
        .change_out (change_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at a falling edge: the coin is sampled on the next rising edge.
    task automatic coin(input logic n, input logic d, input logic q, input int hold,
                        input bit vend, input int ch);
        exp_t e;
        nickel_in  = n;
        dime_in    = d;
        quarter_in = q;
        if (vend) begin
            e.cyc = cyc + 1;
            e.ch  = ch;
            expq.push_back(e);
        end
        repeat (hold) @(negedge clk);
        nickel_in  = 1'b0;
        dime_in    = 1'b0;
        quarter_in = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        vectors    = 0;
        errors     = 0;
        reset      = 1'b0;
        nickel_in  = 1'b0;
        dime_in    = 1'b0;
        quarter_in = 1'b0;

        fork
            forever begin
                exp_t m;
                @(negedge clk);
                if (soda_out) begin
                    if (expq.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_vend: soda_out=1 change=%0d, expected no vend (cycle %0d)",
                                 change_out, cyc);
                    end else begin
                        m = expq.pop_front();
                        chk("vend_cycle", cyc, m.cyc);
                        chk("vend_change", int'(change_out), m.ch);
                    end
                end else begin
                    if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                        m = expq.pop_front();
                        vectors++;
                        errors++;
                        $display("FAIL missing_vend: soda_out=0, expected vend change=%0d at cycle %0d",
                                 m.ch, m.cyc);
                    end
                    chk("idle_change", int'(change_out), 0);
                end
            end
        join_none

        #1;
        chk("reset_soda", int'(soda_out), 0);
        chk("reset_change", int'(change_out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // dime, idle, nickel -> vend with no change
        coin(0, 1, 0, 1, 0, 0); idle();
        coin(1, 0, 0, 1, 1, 0); idle();
        // quarter from S0 -> change 2
        coin(0, 0, 1, 1, 1, 2); idle();
        // dime, idle, dime -> vend on the second dime only, change 1
        coin(0, 1, 0, 1, 0, 0); idle();
        coin(0, 1, 0, 1, 1, 1); idle();
        // S10 + quarter -> change 4, then three nickels
        coin(0, 1, 0, 1, 0, 0); idle();
        coin(0, 0, 1, 1, 1, 4); idle();
        coin(1, 0, 0, 1, 0, 0); idle();
        coin(1, 0, 0, 1, 0, 0); idle();
        coin(1, 0, 0, 1, 1, 0); idle();
        // simultaneous dime+quarter -> quarter only
        coin(0, 1, 1, 1, 1, 2); idle();
        // simultaneous nickel+dime -> dime only (S10), then nickel completes
        coin(1, 1, 0, 1, 0, 0); idle();
        coin(1, 0, 0, 1, 1, 0); idle();
        // simultaneous nickel+quarter -> quarter only
        coin(1, 0, 1, 1, 1, 2); idle();
        // dime held 5 cycles counts once: S10, then nickel completes
        coin(0, 1, 0, 5, 0, 0); idle();
        coin(1, 0, 0, 1, 1, 0); idle();
        // back-to-back vends on consecutive edges
        coin(0, 1, 0, 1, 0, 0); idle();
        coin(1, 0, 0, 1, 1, 0);
        coin(0, 0, 1, 1, 1, 2); idle();

        // async reset while in S10 discards credit
        coin(0, 1, 0, 1, 0, 0); idle();
        #2 reset = 1'b0;
        #1;
        chk("async_reset_soda", int'(soda_out), 0);
        chk("async_reset_change", int'(change_out), 0);
        @(negedge clk);
        reset = 1'b1;
        coin(1, 0, 0, 1, 0, 0); idle();
        coin(0, 1, 0, 1, 1, 0); idle();

        // async reset clears a live dispense pulse immediately
        quarter_in = 1'b1;
        @(posedge clk);
        #1;
        chk("pulse_soda", int'(soda_out), 1);
        chk("pulse_change", int'(change_out), 2);
        #1 reset = 1'b0;
        #1;
        chk("pulse_cleared_soda", int'(soda_out), 0);
        chk("pulse_cleared_change", int'(change_out), 0);
        @(negedge clk);
        quarter_in = 1'b0;
        reset      = 1'b1;
        idle();

        // coin already high when reset releases counts on the first edge
        reset   = 1'b0;
        dime_in = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        dime_in = 1'b0;
        idle();
        coin(1, 0, 0, 1, 1, 0); idle();

        repeat (3) @(negedge clk);
        #1;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            errors++;
            $display("FAIL missing_vend: no pulse seen, expected vend change=%0d at cycle %0d", e.ch, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 nickel_in  input  1  coin-sense level for a 5-cent coin.
REQ-005 dime_in  input  1  coin-sense level for a 10-cent coin.
REQ-006 quarter_in  input  1  coin-sense level for a 25-cent coin.
REQ-007 soda_out  output  1  one-cycle dispense pulse.
REQ-008 change_out  output  4  change returned with a dispense, unsigned, in units of nickels (5 cents); 0 when no dispense.
REQ-009 PRICE  parameter, default 15  soda price in cents; it SHALL be a multiple of 5 in the range 5..35.

Function
REQ-010 Coin detection SHALL be edge-based: a coin is accepted on a rising clk edge where its input is 1 and its registered previous-cycle sample is 0. An input held high for N cycles SHALL count as one coin.
REQ-011 If more than one coin rises on the same edge, only the highest-value coin SHALL be accepted (quarter > dime > nickel). The others are discarded; their edge is consumed.
REQ-012 Credit SHALL be held in a state machine with states S0 (0c), S5 (5c) and S10 (10c), one state per multiple of 5 below PRICE.
REQ-013 On an accepted coin: total = credit + coin value. If total < PRICE, the state SHALL advance to the state for total, and soda_out and change_out SHALL be 0.
REQ-014 On an accepted coin with total >= PRICE, on that same edge:
- soda_out SHALL be set to 1;
- change_out SHALL be set to (total - PRICE)/5;
- the state SHALL return to S0.
REQ-015 Change range with PRICE=15 SHALL be 0..4 nickels, for a maximum total of 35c (S10 + quarter). No overflow of the 4-bit output is possible.
REQ-016 soda_out and change_out SHALL be registered outputs. They SHALL stay asserted for exactly one cycle, then return to 0 on the next edge unless another vend occurs on that edge.
REQ-017 With no accepted coin, the state SHALL hold. Credit SHALL never time out.
REQ-018 Back-to-back vends on consecutive edges are legal. Each vend SHALL produce its own one-cycle pulse and its own change value.
REQ-019 The block SHALL never hold credit >= PRICE, and SHALL never dispense without a completing coin.

Reset
REQ-020 While reset=0, asynchronously:
- state = S0;
- soda_out = 0;
- change_out = 0;
- all coin previous-sample registers = 0.
REQ-021 Reset asserted mid-transaction SHALL discard accumulated credit with no dispense and no change.
REQ-022 After reset deasserts, a coin input already high SHALL count as a new coin on the first edge, because its previous sample is 0.

Verification
REQ-023 Reset, then dime pulse, then nickel pulse (one cycle each, one idle cycle between) -> state S10 after the dime; soda_out=1 and change_out=0 for one cycle after the nickel edge; state S0.
REQ-024 From S0, quarter pulse -> soda_out=1 and change_out=2 (10c) for one cycle; state S0.
REQ-025 From S0, dime, idle, dime -> soda_out=1 and change_out=1 on the second dime edge; no output on the first.
REQ-026 From S10, quarter -> soda_out=1 and change_out=4; nickel x3 -> vend on the third nickel with change_out=0.
REQ-027 Dime and quarter rising on the same edge from S0 -> only the quarter is counted (change_out=2). Dime held high for 5 cycles -> counted once (state S10, no vend).
REQ-028 Reset asserted asynchronously while in S10 -> outputs 0 and state S0 immediately; a following nickel -> S5 and no vend.
